// File: rtl/fft_pkg.sv
// Shared types and arithmetic helpers for the twiddle butterfly.
//   DW      : sample / twiddle component width, signed Q1.(DW-1)
//   PW      : width of the widened product-sum path (2*DW+1)
//   cplx_t  : packed complex sample {re, im}
//   RND     : round-half-up constant added before the >>> (DW-1)
//   sat_hit : true when a PW-bit value lies outside the DW-bit range
//   sat     : clamp a PW-bit value into the DW-bit range
package fft_pkg;

  localparam int unsigned DW = 16;
  localparam int unsigned PW = 2 * DW + 1;

  typedef struct packed {
    logic signed [DW-1:0] re;
    logic signed [DW-1:0] im;
  } cplx_t;

  localparam logic signed [PW-1:0] RND     = {{(DW + 2){1'b0}}, 1'b1, {(DW - 2){1'b0}}};
  localparam logic signed [PW-1:0] SAT_MAX = {{(DW + 2){1'b0}}, {(DW - 1){1'b1}}};
  localparam logic signed [PW-1:0] SAT_MIN = {{(DW + 2){1'b1}}, {(DW - 1){1'b0}}};

  function automatic logic sat_hit(input logic signed [PW-1:0] v);
    return (v > SAT_MAX) || (v < SAT_MIN);
  endfunction

  function automatic logic signed [DW-1:0] sat(input logic signed [PW-1:0] v);
    if (v > SAT_MAX) begin
      return SAT_MAX[DW-1:0];
    end else if (v < SAT_MIN) begin
      return SAT_MIN[DW-1:0];
    end else begin
      return v[DW-1:0];
    end
  endfunction

endpackage

// File: rtl/twiddle_butterfly_cmplx_mul.sv
// cmplx_mul: pipeline stages 1-2 of the butterfly, T = B * W.
//   Stage 1 registers the four full-width signed products.
//   Stage 2 combines them, rounds half up, shifts by DW-1 and saturates.
// Ports:
//   clk, rst_n     clock, async active-low reset (valid bits only)
//   en             global advance; all stage registers hold when low
//   in_valid       valid for the B/W pair presented this cycle
//   b, w           complex multiplicand and twiddle
//   out_valid      stage-2 valid
//   t              rounded, saturated product
//   sat_fire       a valid stage-1 entry saturates as it advances
module cmplx_mul
  import fft_pkg::*;
(
  input  logic  clk,
  input  logic  rst_n,
  input  logic  en,
  input  logic  in_valid,
  input  cplx_t b,
  input  cplx_t w,
  output logic  out_valid,
  output cplx_t t,
  output logic  sat_fire
);

  function automatic logic signed [2*DW-1:0] sx2(input logic signed [DW-1:0] x);
    return {{DW{x[DW-1]}}, x};
  endfunction

  logic                   v1_q, v1_d, v2_q, v2_d;
  logic signed [2*DW-1:0] p_rr_q, p_rr_d, p_ii_q, p_ii_d;
  logic signed [2*DW-1:0] p_ri_q, p_ri_d, p_ir_q, p_ir_d;
  cplx_t                  t_q, t_d;
  logic signed [PW-1:0]   tr_w, ti_w, tr_sh, ti_sh;

  always_comb begin
    v1_d   = v1_q;
    v2_d   = v2_q;
    p_rr_d = p_rr_q;
    p_ii_d = p_ii_q;
    p_ri_d = p_ri_q;
    p_ir_d = p_ir_q;
    t_d    = t_q;

    tr_w  = {p_rr_q[2*DW-1], p_rr_q} - {p_ii_q[2*DW-1], p_ii_q};
    ti_w  = {p_ri_q[2*DW-1], p_ri_q} + {p_ir_q[2*DW-1], p_ir_q};
    tr_sh = (tr_w + RND) >>> (DW - 1);
    ti_sh = (ti_w + RND) >>> (DW - 1);

    sat_fire = en & v1_q & (sat_hit(tr_sh) | sat_hit(ti_sh));

    if (en) begin
      v1_d   = in_valid;
      v2_d   = v1_q;
      p_rr_d = sx2(b.re) * sx2(w.re);
      p_ii_d = sx2(b.im) * sx2(w.im);
      p_ri_d = sx2(b.re) * sx2(w.im);
      p_ir_d = sx2(b.im) * sx2(w.re);
      t_d.re = sat(tr_sh);
      t_d.im = sat(ti_sh);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      v1_q <= 1'b0;
      v2_q <= 1'b0;
    end else begin
      v1_q <= v1_d;
      v2_q <= v2_d;
    end
  end

  always_ff @(posedge clk) begin
    p_rr_q <= p_rr_d;
    p_ii_q <= p_ii_d;
    p_ri_q <= p_ri_d;
    p_ir_q <= p_ir_d;
    t_q    <= t_d;
  end

  assign out_valid = v2_q;
  assign t         = t_q;

endmodule

// File: rtl/twiddle_butterfly.sv
// twiddle_butterfly: 3-stage radix-2 DIT butterfly, X = A + B*W, Y = A - B*W.
//   Stages 1-2 live in cmplx_mul; stage 3 (add/sub, output scaling) and the
//   valid/ready handshake live here. One global stall holds every stage.
// Ports:
//   clk, rst_n                  clock, async active-low reset
//   a_*, b_*, w_*               inputs A, B, twiddle W (signed Q1.15)
//   in_valid / in_ready         input handshake
//   x_*, y_*                    outputs X, Y
//   out_valid / out_ready       output handshake
//   ovf / ovf_clr               sticky saturation flag, synchronous clear
// Build option: BFLY_SCALE_EN scales each output by 1/2 (round half up)
// instead of saturating the sums.
module twiddle_butterfly #(
  parameter int unsigned DW = fft_pkg::DW
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic [DW-1:0] a_re,
  input  logic [DW-1:0] a_im,
  input  logic [DW-1:0] b_re,
  input  logic [DW-1:0] b_im,
  input  logic [DW-1:0] w_re,
  input  logic [DW-1:0] w_im,
  input  logic          in_valid,
  output logic          in_ready,
  output logic [DW-1:0] x_re,
  output logic [DW-1:0] x_im,
  output logic [DW-1:0] y_re,
  output logic [DW-1:0] y_im,
  output logic          out_valid,
  input  logic          out_ready,
  output logic          ovf,
  input  logic          ovf_clr
);

  import fft_pkg::*;

`ifdef BFLY_SCALE_EN
  // (s + 1) >>> 1: bits [DW:1] of the 17-bit sum plus one; cannot overflow.
  function automatic logic signed [DW-1:0] half(input logic signed [DW:0] s);
    logic [DW:0] r;
    r = s + (DW + 1)'(1);
    return r[DW:1];
  endfunction
`else
  function automatic logic signed [PW-1:0] sext(input logic signed [DW:0] s);
    return {{(PW - DW - 1){s[DW]}}, s};
  endfunction
`endif

  logic              stall, en;
  logic              v2, mul_sat, sum_hit;
  cplx_t             b_in, w_in, t2;
  cplx_t             a1_q, a1_d, a2_q, a2_d;
  cplx_t             x_q, x_d, y_q, y_d, x_n, y_n;
  logic              out_valid_q, out_valid_d, ovf_q, ovf_d;
  logic signed [DW:0] s_xr, s_xi, s_yr, s_yi;

  assign b_in = '{re: b_re, im: b_im};
  assign w_in = '{re: w_re, im: w_im};

  cmplx_mul u_mul (
    .clk      (clk),
    .rst_n    (rst_n),
    .en       (en),
    .in_valid (in_valid),
    .b        (b_in),
    .w        (w_in),
    .out_valid(v2),
    .t        (t2),
    .sat_fire (mul_sat)
  );

  always_comb begin
    stall = out_valid_q & ~out_ready;
    en    = ~stall;

    a1_d        = a1_q;
    a2_d        = a2_q;
    x_d         = x_q;
    y_d         = y_q;
    out_valid_d = out_valid_q;
    sum_hit     = 1'b0;

    s_xr = {a2_q.re[DW-1], a2_q.re} + {t2.re[DW-1], t2.re};
    s_xi = {a2_q.im[DW-1], a2_q.im} + {t2.im[DW-1], t2.im};
    s_yr = {a2_q.re[DW-1], a2_q.re} - {t2.re[DW-1], t2.re};
    s_yi = {a2_q.im[DW-1], a2_q.im} - {t2.im[DW-1], t2.im};

`ifdef BFLY_SCALE_EN
    x_n.re = half(s_xr);
    x_n.im = half(s_xi);
    y_n.re = half(s_yr);
    y_n.im = half(s_yi);
`else
    sum_hit = v2 & (sat_hit(sext(s_xr)) | sat_hit(sext(s_xi)) |
                    sat_hit(sext(s_yr)) | sat_hit(sext(s_yi)));
    x_n.re = sat(sext(s_xr));
    x_n.im = sat(sext(s_xi));
    y_n.re = sat(sext(s_yr));
    y_n.im = sat(sext(s_yi));
`endif

    if (en) begin
      a1_d        = '{re: a_re, im: a_im};
      a2_d        = a1_q;
      x_d         = x_n;
      y_d         = y_n;
      out_valid_d = v2;
    end

    // Saturation events count only as their stage advances, so a stalled
    // entry is flagged once and a concurrent clear still loses to it.
    ovf_d = (ovf_q & ~ovf_clr) | mul_sat | (en & sum_hit);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_valid_q <= 1'b0;
      ovf_q       <= 1'b0;
      x_q         <= '0;
      y_q         <= '0;
    end else begin
      out_valid_q <= out_valid_d;
      ovf_q       <= ovf_d;
      x_q         <= x_d;
      y_q         <= y_d;
    end
  end

  always_ff @(posedge clk) begin
    a1_q <= a1_d;
    a2_q <= a2_d;
  end

  assign in_ready  = en;
  assign out_valid = out_valid_q;
  assign ovf       = ovf_q;
  assign x_re      = x_q.re;
  assign x_im      = x_q.im;
  assign y_re      = y_q.re;
  assign y_im      = y_q.im;

endmodule

// File: tb/tb_twiddle_butterfly.sv
module tb_twiddle_butterfly;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [15:0] a_re, a_im, b_re, b_im, w_re, w_im;
  logic        in_valid, in_ready;
  logic [15:0] x_re, x_im, y_re, y_im;
  logic        out_valid, out_ready;
  logic        ovf, ovf_clr;

  always #5 clk = ~clk;

  twiddle_butterfly #(.DW(16)) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .a_re     (a_re),
    .a_im     (a_im),
    .b_re     (b_re),
    .b_im     (b_im),
    .w_re     (w_re),
    .w_im     (w_im),
    .in_valid (in_valid),
    .in_ready (in_ready),
    .x_re     (x_re),
    .x_im     (x_im),
    .y_re     (y_re),
    .y_im     (y_im),
    .out_valid(out_valid),
    .out_ready(out_ready),
    .ovf      (ovf),
    .ovf_clr  (ovf_clr)
  );

  int unsigned n_chk  = 0;
  int unsigned n_fail = 0;

  task automatic check(input string tag, input logic [15:0] got, input logic [15:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  // Reference: exact integer arithmetic of X = A + B*W, Y = A - B*W in Q1.15.
  typedef struct {
    longint xr, xi, yr, yi;
    bit     sat;
  } exp_t;

  function automatic bit oor(longint v);
    return (v > 32767) || (v < -32768);
  endfunction

  function automatic longint clamp(longint v);
    if (v > 32767) return 32767;
    if (v < -32768) return -32768;
    return v;
  endfunction

  function automatic exp_t model(longint ar, longint ai, longint br, longint bi,
                                 longint wr, longint wi);
    exp_t   e;
    longint tr, ti, s[4];
    tr = (br * wr - bi * wi + 16384) >>> 15;
    ti = (br * wi + bi * wr + 16384) >>> 15;
    e.sat = oor(tr) || oor(ti);
    tr = clamp(tr);
    ti = clamp(ti);
    s[0] = ar + tr; s[1] = ai + ti; s[2] = ar - tr; s[3] = ai - ti;
`ifdef BFLY_SCALE_EN
    for (int i = 0; i < 4; i++) s[i] = (s[i] + 1) >>> 1;
`else
    for (int i = 0; i < 4; i++) begin
      if (oor(s[i])) e.sat = 1'b1;
      s[i] = clamp(s[i]);
    end
`endif
    e.xr = s[0]; e.xi = s[1]; e.yr = s[2]; e.yi = s[3];
    return e;
  endfunction

  exp_t sb[$];
  int   out_cnt  = 0;
  bit   sat_seen = 1'b0;

  // Scoreboard: compare the head entry whenever out_valid is shown (covers
  // stability under stall), retire it on a transfer, enqueue accepted inputs.
  always @(negedge clk) begin
    if (rst_n === 1'b1) begin
      if (out_valid) begin
        if (sb.size() == 0) begin
          check("spurious_out", out_valid, 1'b0);
        end else begin
          exp_t e;
          logic [15:0] ev;
          e = sb[0];
          ev = 16'(e.xr); check("x_re", x_re, ev);
          ev = 16'(e.xi); check("x_im", x_im, ev);
          ev = 16'(e.yr); check("y_re", y_re, ev);
          ev = 16'(e.yi); check("y_im", y_im, ev);
          if (out_ready) begin
            void'(sb.pop_front());
            out_cnt++;
          end
        end
      end
      if (in_valid && in_ready) begin
        exp_t e;
        e = model(longint'($signed(a_re)), longint'($signed(a_im)),
                  longint'($signed(b_re)), longint'($signed(b_im)),
                  longint'($signed(w_re)), longint'($signed(w_im)));
        if (e.sat) sat_seen = 1'b1;
        sb.push_back(e);
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [15:0] rnd16();
    case ($urandom_range(0, 7))
      0:       return 16'h8000;
      1:       return 16'h7FFF;
      default: return 16'($urandom);
    endcase
  endfunction

  task automatic drive(input logic [15:0] ar, ai, br, bi, wr, wi);
    a_re = ar; a_im = ai; b_re = br; b_im = bi; w_re = wr; w_im = wi;
  endtask

  task automatic drive_rand();
    drive(rnd16(), rnd16(), rnd16(), rnd16(), rnd16(), rnd16());
  endtask

  // One butterfly into an idle pipeline; returns cycles until out_valid.
  task automatic single(input logic [15:0] ar, ai, br, bi, wr, wi, output int lat);
    drive(ar, ai, br, bi, wr, wi);
    in_valid = 1'b1;
    tick();
    in_valid = 1'b0;
    lat = 1;
    while (!out_valid && lat < 20) begin
      tick();
      lat++;
    end
  endtask

  task automatic drain(input string tag);
    int k;
    in_valid  = 1'b0;
    out_ready = 1'b1;
    k = 0;
    while (sb.size() != 0 && k < 100) begin
      tick();
      k++;
    end
    tick();
    check(tag, 16'(sb.size()), 16'd0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    int lat, base;
    logic [15:0] exp_v;

    rst_n = 1'b0; in_valid = 1'b0; out_ready = 1'b1; ovf_clr = 1'b0;
    drive('0, '0, '0, '0, '0, '0);
    repeat (3) tick();
    check("rst_out_valid", out_valid, 1'b0);
    check("rst_in_ready", in_ready, 1'b1);
    check("rst_ovf", ovf, 1'b0);
    check("rst_x_re", x_re, 16'h0);
    check("rst_x_im", x_im, 16'h0);
    check("rst_y_re", y_re, 16'h0);
    check("rst_y_im", y_im, 16'h0);
    rst_n = 1'b1;
    tick();
    check("post_rst_in_ready", in_ready, 1'b1);

    // Real-axis butterfly
    single(16'h1000, 16'h0, 16'h2000, 16'h0, 16'h7FFF, 16'h0, lat);
    check("lat_real", 16'(lat), 16'd3);
`ifdef BFLY_SCALE_EN
    check("real_x_re", x_re, 16'h1800);
    check("real_y_re", y_re, 16'hF800);
`else
    check("real_x_re", x_re, 16'h3000);
    check("real_y_re", y_re, 16'hF000);
`endif
    check("real_x_im", x_im, 16'h0);
    check("real_ovf", ovf, 1'b0);
    tick();

    // Imaginary twiddle: B*j rotation
    single(16'h0, 16'h0, 16'h4000, 16'h0, 16'h0, 16'h7FFF, lat);
    check("lat_imag", 16'(lat), 16'd3);
    check("imag_x_re", x_re, 16'h0);
`ifdef BFLY_SCALE_EN
    check("imag_x_im", x_im, 16'h2000);
    check("imag_y_im", y_im, 16'hE000);
`else
    check("imag_x_im", x_im, 16'h4000);
    check("imag_y_im", y_im, 16'hC000);
`endif
    check("imag_ovf", ovf, 1'b0);
    tick();

    // (-1)*(-1) saturates the product
    single(16'h0, 16'h0, 16'h8000, 16'h0, 16'h8000, 16'h0, lat);
    check("lat_sat", 16'(lat), 16'd3);
`ifdef BFLY_SCALE_EN
    check("sat_x_re", x_re, 16'h4000);
    check("sat_y_re", y_re, 16'hC001);
`else
    check("sat_x_re", x_re, 16'h7FFF);
    check("sat_y_re", y_re, 16'h8001);
`endif
    check("sat_x_im", x_im, 16'h0);
    check("sat_ovf_set", ovf, 1'b1);
    tick(); tick();
    check("sat_ovf_sticky", ovf, 1'b1);
    ovf_clr = 1'b1;
    tick();
    ovf_clr = 1'b0;
    check("sat_ovf_cleared", ovf, 1'b0);
    tick();
    check("sat_ovf_stays_clear", ovf, 1'b0);
    drain("drain_directed");

    // Back-to-back 8 with out_ready low in cycles 4-6
    base = out_cnt;
    begin
      int idx;
      idx = 0;
      for (int c = 0; c < 12; c++) begin
        out_ready = !(c >= 4 && c <= 6);
        in_valid  = (idx < 8);
        drive_rand();
        @(negedge clk);
        exp_v = (c >= 4 && c <= 6) ? 16'd0 : 16'd1;
        check("stall_in_ready", in_ready, exp_v);
        if (in_valid && in_ready) idx++;
        tick();
      end
      in_valid = 1'b0;
      check("stall_accepted", 16'(idx), 16'd8);
    end
    drain("drain_stall");
    check("stall_out_count", 16'(out_cnt - base), 16'd8);

    // Reset with two butterflies in flight
    out_ready = 1'b0;
    drive_rand(); in_valid = 1'b1;
    tick();
    drive_rand();
    tick();
    in_valid = 1'b0;
    tick();
    check("inflight_out_valid", out_valid, 1'b1);
    #1 rst_n = 1'b0;
    #1;
    check("async_rst_out_valid", out_valid, 1'b0);
    check("async_rst_in_ready", in_ready, 1'b1);
    check("async_rst_x_re", x_re, 16'h0);
    @(negedge clk);
    #1 rst_n = 1'b1;
    sb.delete();
    out_ready = 1'b1;
    for (int i = 0; i < 6; i++) begin
      tick();
      check("flushed_no_output", out_valid, 1'b0);
    end
    single(rnd16(), rnd16(), rnd16(), rnd16(), rnd16(), rnd16(), lat);
    check("lat_after_rst", 16'(lat), 16'd3);
    drain("drain_rst");

    // Randomized traffic with random back-pressure
    ovf_clr = 1'b1;
    tick();
    ovf_clr = 1'b0;
    sat_seen = 1'b0;
    base = out_cnt;
    for (int i = 0; i < 400; i++) begin
      in_valid  = ($urandom_range(0, 3) != 0);
      out_ready = ($urandom_range(0, 3) != 0);
      drive_rand();
      tick();
    end
    drain("drain_rand");
    check("rand_ovf", ovf, sat_seen);
    check("rand_some_outputs", 16'(out_cnt - base > 100), 16'd1);

    $display("[TB] %0d tests run, %0d failed", n_chk, n_fail);
    $finish;
  end

endmodule

// File: doc/twiddle_butterfly.md
TWIDDLE_BUTTERFLY -- requirements
Module: twiddle_butterfly

Interface
REQ-001 Parameter DW, default 16: sample and twiddle component width, two's complement Q1.(DW-1); all widths below are for DW=16.
REQ-002 clk  input  1  single clock; all state on rising edge.
REQ-003 rst_n  input  1  reset, asynchronous assert, active-low.
REQ-004 a_re, a_im  input  16 each  butterfly upper input A, signed Q1.15.
REQ-005 b_re, b_im  input  16 each  butterfly lower input B, signed Q1.15.
REQ-006 w_re, w_im  input  16 each  twiddle factor W, signed Q1.15.
REQ-007 in_valid  input  1 / in_ready  output  1  input handshake; transfer when both high.
REQ-008 x_re, x_im, y_re, y_im  output  16 each  results X = A + B*W, Y = A - B*W.
REQ-009 out_valid  output  1 / out_ready  input  1  output handshake; transfer when both high.
REQ-010 ovf  output  1  sticky saturation flag; ovf_clr  input  1  synchronous clear.

Function
REQ-011 Three-stage pipeline, latency exactly 3 cycles from input transfer to out_valid when not stalled; throughput one butterfly per cycle.
REQ-012 Stage 1 SHALL register A and the four signed 32-bit products b_re*w_re, b_im*w_im, b_re*w_im, b_im*w_re (full sign extension, no truncation).
REQ-013 Stage 2 SHALL form t_re = p_rr - p_ii and t_im = p_ri + p_ir at 33 bits, round by adding 2^14, arithmetic shift right 15, saturate to [-32768, 32767].
REQ-014 Stage 3 SHALL form 17-bit sums A+T and A-T, then apply output scaling per REQ-022/023.
REQ-015 Global stall: all stage registers hold while out_valid=1 and out_ready=0; in_ready = !(out_valid && !out_ready).
REQ-016 Per-stage valid bit travels with data; bubbles propagate, never duplicate or drop a transfer.
REQ-017 Output data stable while out_valid=1 and out_ready=0.
REQ-018 ovf set in the cycle any saturation in REQ-013 or REQ-023 fires on a valid stage; ovf_clr and a same-cycle set: set wins.
REQ-019 Data registers of invalid stages are don't-care; only valid bits and ovf are reset.

Reset
REQ-020 rst_n low SHALL asynchronously clear all stage valid bits, out_valid=0, ovf=0; in_ready=1 after release; in-flight data discarded, no output produced for it.
REQ-021 Data outputs reset to 0.

Configuration
REQ-022 Macro BFLY_SCALE_EN defined: each 17-bit sum SHALL be computed as (sum + 1) >>> 1 (scale by 1/2, round half up); never saturates.
REQ-023 BFLY_SCALE_EN undefined: each 17-bit sum SHALL saturate to [-32768, 32767] with no scaling.

Structure
REQ-024 Package fft_pkg SHALL hold DW, the Q1.15 complex typedef (re/im struct), rounding constant 2^14 and the saturation helper function.
REQ-025 One sub-module cmplx_mul (stages 1-2, four products, round, saturate) instantiated once; butterfly add/sub and handshake in the top.

Verification
REQ-026 A=(0x1000,0), B=(0x2000,0), W=(0x7FFF,0), no scale -> after 3 cycles X=(0x3000,0), Y=(0xF000,0), ovf=0; with BFLY_SCALE_EN X=(0x1800,0), Y=(0xF800,0).
REQ-027 A=0, B=(0x4000,0), W=(0,0x7FFF) -> X=(0,0x4000), Y=(0,0xC000).
REQ-028 A=0, B=(0x8000,0), W=(0x8000,0) -> t_re saturates, X=(0x7FFF,0), ovf=1 until ovf_clr pulse, then 0.
REQ-029 Back-to-back 8 inputs with out_ready low for cycles 4-6 -> all 8 outputs in order, none lost or repeated, in_ready low exactly while stalled.
REQ-030 rst_n pulsed low with 2 butterflies in flight -> out_valid=0 immediately, no output for them, next input emerges 3 cycles after acceptance.
